instruction_sequencer: RTL and testbench

Program-memory-based sequencer that feeds the MasterController its `instruction` word, one per cycle, in place of the testbench file reader. A host loads a program through a write port and pulses `start`. The sequencer then steps a program counter and forwards datapath instructions. It executes three sequencer-private control opcodes locally: loop start, loop end with repeat count, and halt. It sits between the host interface and `MasterController.instruction`.

---
 rtl/instruction_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Program-memory sequencer feeding the MasterController one instruction word per cycle.
// Executes loop-start, loop-end (with repeat count) and halt locally; all other words are forwarded.
module instruction_sequencer #(
    parameter int depth = 2,
    parameter int W     = 8,
    parameter int PA    = 6,
    localparam int insW     = (depth > 2) ? depth : 2,
    localparam int insD     = ((1 << depth) > W) ? (1 << depth) : W,
    localparam int insWidth = 4 + 2 + 2 * insW + insD
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                progWrite,
    input  logic [PA-1:0]       progAddr,
    input  logic [insWidth-1:0] progData,
    input  logic                start,
    input  logic                stall,
    output logic [insWidth-1:0] instruction,
    output logic                insValid,
    output logic                busy,
    output logic                done,
    output logic [PA-1:0]       pc
);

    localparam int MEM_WORDS = 1 << PA;

    localparam logic [3:0] OP_HALT   = 4'b1101;
    localparam logic [3:0] OP_LSTART = 4'b1110;
    localparam logic [3:0] OP_LEND   = 4'b1111;

    localparam logic [PA-1:0]       PC_ZERO  = {PA{1'b0}};
    localparam logic [PA-1:0]       PC_ONE   = PA'(1'b1);
    localparam logic [PA-1:0]       PC_LAST  = {PA{1'b1}};
    localparam logic [insD-1:0]     CNT_ZERO = {insD{1'b0}};
    localparam logic [insD-1:0]     CNT_ONE  = insD'(1'b1);
    localparam logic [insWidth-1:0] WORD_ZERO = {insWidth{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [insWidth-1:0] mem_r [MEM_WORDS];

    logic [PA-1:0]       pc_r;
    logic [PA-1:0]       pc_s;
    logic [PA-1:0]       loop_start_r;
    logic [PA-1:0]       loop_start_s;
    logic [insD-1:0]     loop_cnt_r;
    logic [insD-1:0]     loop_cnt_s;
    logic                loop_active_r;
    logic                loop_active_s;
    logic [insWidth-1:0] instruction_r;
    logic [insWidth-1:0] instruction_s;
    logic                ins_valid_r;
    logic                ins_valid_s;
    logic                busy_r;
    logic                busy_s;
    logic                done_r;
    logic                done_s;

    logic [insWidth-1:0] cur_word_s;
    logic [3:0]          opcode_s;
    logic [insD-1:0]     repeat_s;
    logic                at_last_s;
    logic                exec_s;
    logic                lend_arm_s;
    logic                lend_repeat_s;
    logic                lend_jump_s;
    logic                is_ctrl_s;

    // Word decode at the current program counter (asynchronous memory read)
    always_comb begin
        cur_word_s    = mem_r[pc_r];
        opcode_s      = cur_word_s[insWidth-1 -: 4];
        repeat_s      = cur_word_s[insD-1:0];
        at_last_s     = (pc_r == PC_LAST);
        exec_s        = (state_r == ST_RUN) && !stall;
        lend_arm_s    = !loop_active_r && (repeat_s != CNT_ZERO);
        lend_repeat_s = loop_active_r && (loop_cnt_r != CNT_ZERO);
        lend_jump_s   = lend_arm_s || lend_repeat_s;
        is_ctrl_s     = (opcode_s == OP_HALT) || (opcode_s == OP_LSTART) || (opcode_s == OP_LEND);
    end

    // Program memory write port; locked while a program is running
    always_ff @(posedge CLK) begin
        if (progWrite && (state_r != ST_RUN)) begin
            mem_r[progAddr] <= progData;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; the last address never wraps, it ends the run instead
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (!exec_s) begin
                    state_s = ST_RUN;
                end else begin
                    case (opcode_s)
                        OP_HALT: state_s = ST_DONE;
                        OP_LEND: begin
                            if (!lend_jump_s && at_last_s) begin
                                state_s = ST_DONE;
                            end else begin
                                state_s = ST_RUN;
                            end
                        end
                        default: begin
                            if (at_last_s) begin
                                state_s = ST_DONE;
                            end else begin
                                state_s = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: forwarded word, valid flag and status flags
    always_comb begin
        instruction_s = WORD_ZERO;
        ins_valid_s   = 1'b0;
        if (exec_s && !is_ctrl_s) begin
            instruction_s = cur_word_s;
            ins_valid_s   = 1'b1;
        end else begin
            instruction_s = WORD_ZERO;
            ins_valid_s   = 1'b0;
        end
        busy_s = (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
    end

    // Program counter and single-level loop bookkeeping
    always_comb begin
        pc_s          = pc_r;
        loop_start_s  = loop_start_r;
        loop_cnt_s    = loop_cnt_r;
        loop_active_s = loop_active_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_s          = PC_ZERO;
                    loop_start_s  = PC_ZERO;
                    loop_cnt_s    = CNT_ZERO;
                    loop_active_s = 1'b0;
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_RUN: begin
                if (exec_s) begin
                    case (opcode_s)
                        OP_HALT: pc_s = pc_r;
                        OP_LSTART: begin
                            loop_start_s = pc_r + PC_ONE;
                            if (!at_last_s) begin
                                pc_s = pc_r + PC_ONE;
                            end else begin
                                pc_s = pc_r;
                            end
                        end
                        OP_LEND: begin
                            if (lend_arm_s) begin
                                loop_cnt_s    = repeat_s - CNT_ONE;
                                loop_active_s = 1'b1;
                                pc_s          = loop_start_r;
                            end else if (lend_repeat_s) begin
                                loop_cnt_s = loop_cnt_r - CNT_ONE;
                                pc_s       = loop_start_r;
                            end else begin
                                loop_active_s = 1'b0;
                                if (!at_last_s) begin
                                    pc_s = pc_r + PC_ONE;
                                end else begin
                                    pc_s = pc_r;
                                end
                            end
                        end
                        default: begin
                            if (!at_last_s) begin
                                pc_s = pc_r + PC_ONE;
                            end else begin
                                pc_s = pc_r;
                            end
                        end
                    endcase
                end else begin
                    pc_s = pc_r;
                end
            end
            default: begin
                pc_s          = PC_ZERO;
                loop_start_s  = PC_ZERO;
                loop_cnt_s    = CNT_ZERO;
                loop_active_s = 1'b0;
            end
        endcase
    end

    // Registered datapath state and outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_r          <= PC_ZERO;
            loop_start_r  <= PC_ZERO;
            loop_cnt_r    <= CNT_ZERO;
            loop_active_r <= 1'b0;
            instruction_r <= WORD_ZERO;
            ins_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            pc_r          <= pc_s;
            loop_start_r  <= loop_start_s;
            loop_cnt_r    <= loop_cnt_s;
            loop_active_r <= loop_active_s;
            instruction_r <= instruction_s;
            ins_valid_r   <= ins_valid_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    assign instruction = instruction_r;
    assign insValid    = ins_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pc          = pc_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: an ISA-level interpreter produces the expected issue trace per executed step;
// random stalls, start pulses and locked-out writes are layered on top of it.
module tb_instruction_sequencer;

    localparam int PA = 3;
    localparam int IW = 18;
    localparam int NW = 1 << PA;

    localparam logic [3:0] OP_HALT   = 4'hD;
    localparam logic [3:0] OP_LSTART = 4'hE;
    localparam logic [3:0] OP_LEND   = 4'hF;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          progWrite;
    logic [PA-1:0] progAddr;
    logic [IW-1:0] progData;
    logic          start;
    logic          stall;
    logic [IW-1:0] instruction;
    logic          insValid;
    logic          busy;
    logic          done;
    logic [PA-1:0] pc;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [IW-1:0] ins;
        logic          valid;
        logic [PA-1:0] pc;
        logic          fin;
    } step_t;

    step_t         exp_q[$];
    logic [IW-1:0] prog [NW];

    instruction_sequencer #(.depth(2), .W(8), .PA(PA)) dut (
        .CLK(CLK), .nRST(nRST), .progWrite(progWrite), .progAddr(progAddr),
        .progData(progData), .start(start), .stall(stall), .instruction(instruction),
        .insValid(insValid), .busy(busy), .done(done), .pc(pc)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [7:0] last);
        return {op, 6'b000000, last};
    endfunction

    function automatic logic [IW-1:0] dp_word();
        logic [3:0]  op;
        logic [13:0] rest;
        op   = 4'($urandom_range(0, 12));
        rest = 14'($urandom);
        return {op, rest};
    endfunction

    // Interpret the program word by word following the instruction-set rules
    task automatic build_model();
        int p, ls, cnt, n;
        bit act, fin;
        logic [IW-1:0] w;
        logic [3:0] op;
        step_t s;
        exp_q.delete();
        p = 0; ls = 0; cnt = 0; act = 0; fin = 0; n = 0;
        while (!fin && n < 400) begin
            w = prog[p];
            op = w[IW-1 -: 4];
            s.ins = '0;
            s.valid = 1'b0;
            if (op == OP_HALT) begin
                fin = 1;
            end else if (op == OP_LSTART) begin
                ls = (p + 1) % NW;
                if (p == NW - 1) fin = 1; else p++;
            end else if (op == OP_LEND) begin
                if (!act && w[7:0] != 0) begin
                    cnt = int'(w[7:0]) - 1; act = 1; p = ls;
                end else if (act && cnt != 0) begin
                    cnt--; p = ls;
                end else begin
                    act = 0;
                    if (p == NW - 1) fin = 1; else p++;
                end
            end else begin
                s.ins = w;
                s.valid = 1'b1;
                if (p == NW - 1) fin = 1; else p++;
            end
            s.pc = p[PA-1:0];
            s.fin = fin;
            exp_q.push_back(s);
            n++;
        end
    endtask

    // Load, start and follow one run; stalls never consume a model step
    task automatic run_program(input int stall_pct, input int stall_at, input bit overlap,
                               input bit wr_run, input bit reload, input int abort_after,
                               input bit rand_start);
        int consumed, cycles, nst, mpc;
        bit st;
        step_t e;
        build_model();
        if (reload) begin
            for (int i = (overlap ? 1 : 0); i < NW; i++) begin
                progWrite = 1'b1; progAddr = PA'(i); progData = prog[i];
                tick();
            end
            progWrite = 1'b0;
        end
        start = 1'b1;
        if (overlap) begin
            progWrite = 1'b1; progAddr = '0; progData = prog[0];
        end
        tick();
        start = 1'b0;
        progWrite = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_done", done, 0);
        check_eq("start_valid", insValid, 0);
        check_eq("start_pc", pc, 0);
        consumed = 0; cycles = 0; nst = 0; mpc = 0;
        while (exp_q.size() > 0 && consumed < abort_after && cycles < 600) begin
            st = ($urandom_range(0, 99) < stall_pct) || (consumed == stall_at && nst < 3);
            if (consumed == stall_at && st) nst++;
            stall = st;
            start = rand_start && ($urandom_range(0, 9) == 0);
            if (wr_run) begin
                progWrite = 1'b1; progAddr = PA'($urandom); progData = IW'($urandom);
            end
            tick();
            cycles++;
            if (st) begin
                check_eq("stall_valid", insValid, 0);
                check_eq("stall_ins", instruction, 0);
                check_eq("stall_pc", pc, mpc);
                check_eq("stall_busy", busy, 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("valid", insValid, e.valid);
                check_eq("ins", instruction, e.ins);
                check_eq("pc", pc, e.pc);
                check_eq("done", done, e.fin);
                check_eq("busy", busy, !e.fin);
                mpc = e.pc;
                consumed++;
            end
        end
        stall = 1'b0; start = 1'b0; progWrite = 1'b0;
        if (consumed < abort_after) begin
            check_eq("run_budget", exp_q.size(), 0);
            tick();
            check_eq("idle_done", done, 1);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_valid", insValid, 0);
            check_eq("idle_pc", pc, mpc);
        end
    endtask

    task automatic fill_nop();
        for (int i = 0; i < NW; i++) prog[i] = '0;
    endtask

    initial begin
        nRST = 1'b0; progWrite = 1'b0; progAddr = '0; progData = '0; start = 1'b0; stall = 1'b0;
        tick(); tick();
        check_eq("rst_ins", instruction, 0);
        check_eq("rst_valid", insValid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pc", pc, 0);
        #2 nRST = 1'b1;
        tick();

        // Straight line, word 0 written on the same edge as start
        fill_nop();
        prog[0] = 18'h00C01; prog[1] = 18'h00C02; prog[2] = 18'h00C03; prog[3] = mk(OP_HALT, 8'h00);
        run_program(0, -1, 1'b1, 1'b0, 1'b1, 1000, 1'b0);

        // Loop body A B repeated N=2 extra times, then C
        fill_nop();
        prog[0] = mk(OP_LSTART, 8'h00); prog[1] = 18'h00A0A; prog[2] = 18'h00B0B;
        prog[3] = mk(OP_LEND, 8'd2);    prog[4] = 18'h00C0C; prog[5] = mk(OP_HALT, 8'h00);
        run_program(0, -1, 1'b0, 1'b0, 1'b1, 1000, 1'b1);

        // LEND with N=0 falls straight through
        fill_nop();
        prog[0] = mk(OP_LSTART, 8'h00); prog[1] = 18'h01111; prog[2] = mk(OP_LEND, 8'd0);
        prog[3] = 18'h02222; prog[4] = mk(OP_HALT, 8'h00);
        run_program(0, -1, 1'b0, 1'b0, 1'b1, 1000, 1'b0);

        // Three stall cycles in the middle of a five-word program
        fill_nop();
        for (int i = 0; i < 5; i++) prog[i] = dp_word();
        prog[5] = mk(OP_HALT, 8'h00);
        run_program(0, 2, 1'b0, 1'b0, 1'b1, 1000, 1'b0);

        // Eight datapath words, no HALT: ends at the last address without wrapping
        for (int i = 0; i < NW; i++) prog[i] = dp_word();
        run_program(0, -1, 1'b0, 1'b0, 1'b1, 1000, 1'b0);

        // Writes during RUN are ignored; a second run replays the original words
        run_program(20, -1, 1'b0, 1'b1, 1'b0, 1000, 1'b0);
        run_program(0, -1, 1'b0, 1'b0, 1'b0, 1000, 1'b0);

        // Asynchronous reset in the middle of a loop, then a clean rerun
        fill_nop();
        prog[0] = mk(OP_LSTART, 8'h00); prog[1] = 18'h00A0A; prog[2] = 18'h00B0B;
        prog[3] = mk(OP_LEND, 8'd3);    prog[4] = 18'h00C0C; prog[5] = mk(OP_HALT, 8'h00);
        run_program(0, -1, 1'b0, 1'b0, 1'b1, 6, 1'b0);
        #2 nRST = 1'b0;
        #1;
        check_eq("arst_ins", instruction, 0);
        check_eq("arst_valid", insValid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_pc", pc, 0);
        tick();
        #2 nRST = 1'b1;
        tick();
        run_program(0, -1, 1'b0, 1'b0, 1'b0, 1000, 1'b0);

        // Randomised programs with at most one loop, random stalls and stray start pulses
        for (int t = 0; t < 12; t++) begin
            int a, b, k;
            for (int i = 0; i < NW; i++) begin
                k = $urandom_range(0, 9);
                if (k < 7) prog[i] = dp_word();
                else if (k < 9 || i < 2) prog[i] = '0;
                else prog[i] = mk(OP_HALT, 8'h00);
            end
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 5);
                b = $urandom_range(a + 1, 7);
                prog[a] = mk(OP_LSTART, 8'h00);
                prog[b] = mk(OP_LEND, 8'($urandom_range(0, 3)));
            end
            run_program($urandom_range(0, 40), -1, 1'b0, 1'b0, 1'b1, 1000, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
